// File: rtl/wb_merge_pkg.sv
// Shared types for the register-file writeback merge stage.
`default_nettype none

package wb_merge_pkg;

    localparam int RF_NUM_DEF         = 32;
    localparam int DIV_FIFO_DEPTH_DEF = 2;

    typedef logic [4:0]  gr_t;
    typedef logic [31:0] dtype_t;

    typedef struct packed {
        logic   en;
        gr_t    rd;
        dtype_t data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_merge_fifo.sv
// Generic synchronous FIFO of writeback requests with an asynchronous active-low reset.
`default_nettype none

module wb_fifo
    import wb_merge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        pop_data = mem[rd_ptr];
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/wb_merge.sv
// Merges in-order pipeline writeback with out-of-order divider results onto
// the single regfile write port; tracks outstanding divider destinations.
`default_nettype none

module wb_merge
    import wb_merge_pkg::*;
#(
    parameter int DIV_FIFO_DEPTH = DIV_FIFO_DEPTH_DEF,
    parameter int RF_NUM         = RF_NUM_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              pipe_valid,
    input  logic              pipe_we,
    input  logic [4:0]        pipe_rd,
    input  logic [31:0]       pipe_data,
    input  logic              div_issue,
    input  logic [4:0]        div_issue_rd,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [4:0]        div_rd,
    input  logic [31:0]       div_data,
    output logic [4:0]        wb_rd,
    output logic              wb_en,
    output logic [31:0]       wb_data,
    output logic [RF_NUM-1:0] busy_mask
);

    localparam int CW = $clog2(DIV_FIFO_DEPTH) + 1;

    logic              pipe_claim;
    logic              div_fire;
    logic              div_nonzero;
    logic              do_pop;
    logic              do_bypass;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    wb_req_t           fifo_head;
    wb_req_t           div_req;
    logic [RF_NUM-1:0] busy_set;
    logic [RF_NUM-1:0] busy_clr;

    wb_fifo #(
        .DEPTH     (DIV_FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (fifo_push),
        .push_data (div_req),
        .pop       (do_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready deliberately ignores a same-cycle pop to keep it off the pop path.
    assign div_ready = (fifo_count < CW'(DIV_FIFO_DEPTH));

    always_comb begin
        pipe_claim   = pipe_valid & pipe_we & (pipe_rd != '0);
        div_fire     = div_valid & div_ready;
        div_nonzero  = (div_rd != '0);
        do_pop       = ~pipe_claim & ~fifo_empty;
        do_bypass    = ~pipe_claim & fifo_empty & div_fire & div_nonzero;
        fifo_push    = div_fire & div_nonzero & ~do_bypass & ~fifo_full;
        div_req.en   = 1'b1;
        div_req.rd   = div_rd;
        div_req.data = div_data;

        busy_set = '0;
        busy_clr = '0;
        if (div_issue && (div_issue_rd != '0)) busy_set[div_issue_rd] = 1'b1;
        if (do_pop && fifo_head.en)            busy_clr[fifo_head.rd] = 1'b1;
        else if (do_bypass)                    busy_clr[div_rd]       = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            busy_mask <= '0;
        end else begin
            if (pipe_claim) begin
                wb_en   <= 1'b1;
                wb_rd   <= pipe_rd;
                wb_data <= pipe_data;
            end else if (do_pop) begin
                wb_en   <= fifo_head.en;
                wb_rd   <= fifo_head.rd;
                wb_data <= fifo_head.data;
            end else if (do_bypass) begin
                wb_en   <= 1'b1;
                wb_rd   <= div_rd;
                wb_data <= div_data;
            end else begin
                wb_en   <= 1'b0;
            end
            // A fresh issue to the same register outranks the retiring write.
            busy_mask <= (busy_mask & ~busy_clr) | busy_set;
        end
    end

endmodule

`default_nettype wire
